// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_pkg
//  Description : Shared defaults and helpers for the LIFO buffer register.
//                Provides the default word width and depth, and the
//                stack-pointer width helper. The pointer must hold the
//                values 0..DEPTH, so it is one bit wider than an index.
//  Revision    : 1.0 - initial release
// ============================================================================
package lifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_DEPTH      = 8;

    // Width of a pointer that counts from 0 up to and including depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_storage.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_storage
//  Description : Register-file array for the LIFO buffer. It has one
//                synchronous write port and one combinational read port.
//                The contents are deliberately not reset.
//  Ports       : clk      - clock
//                wr_en    - write strobe
//                wr_addr  - write index
//                wr_data  - write word
//                rd_addr  - read index
//                rd_data  - word at rd_addr (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_storage #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/lifo_buffer_register.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_buffer_register
//  Description : Hardware stack holding DEPTH words of DATA_WIDTH bits.
//                Each enabled cycle performs either a push (RW=0) or a pop
//                (RW=1). A push when full and a pop when empty are both
//                ignored. dataOut is registered and holds the last word
//                that was popped.
//  Ports       : Clk     - clock, rising edge
//                Rst     - asynchronous active-low reset
//                EN      - operation enable
//                RW      - 0 = push, 1 = pop
//                dataIn  - word to push
//                dataOut - last popped word
//                EMPTY   - no words are stored
//                FULL    - DEPTH words are stored
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_buffer_register
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  EN,
    input  logic                  RW,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  EMPTY,
    output logic                  FULL
);

    localparam int PTR_WIDTH  = ptr_width(DEPTH);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    // sp is the word count, so it also indexes the next free slot.
    logic [PTR_WIDTH-1:0]  sp;
    logic                  do_push;
    logic                  do_pop;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign EMPTY = (sp == '0);
    assign FULL  = (sp == PTR_WIDTH'(DEPTH));

    // Push and pop are gated by the flags, so overflow and underflow
    // requests fall through as no-ops.
    assign do_push = EN & ~RW & ~FULL;
    assign do_pop  = EN &  RW & ~EMPTY;

    // The truncation is safe because a push only happens while sp < DEPTH
    // and a pop only happens while sp >= 1.
    assign wr_addr = ADDR_WIDTH'(sp);
    assign rd_addr = ADDR_WIDTH'(sp - PTR_WIDTH'(1));

    lifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .clk     (Clk),
        .wr_en   (do_push),
        .wr_addr (wr_addr),
        .wr_data (dataIn),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sp      <= '0;
            dataOut <= '0;
        end else if (do_push) begin
            sp      <= sp + PTR_WIDTH'(1);
        end else if (do_pop) begin
            sp      <= sp - PTR_WIDTH'(1);
            dataOut <= rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lifo_buffer_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo_buffer_register
//  Description : Self-checking bench for lifo_buffer_register. A behavioural
//                stack model produces the expected popped words. These are
//                queued when a pop is driven, and dequeued and compared
//                once the DUT output has settled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_buffer_register;

    localparam int DW    = 4;
    localparam int DEPTH = 8;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          EN  = 1'b0;
    logic          RW  = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic [DW-1:0] dataOut;
    logic          EMPTY;
    logic          FULL;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_stk [$];
    logic [DW-1:0] model_out = '0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_word;

    lifo_buffer_register #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .EN      (EN),
        .RW      (RW),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .EMPTY   (EMPTY),
        .FULL    (FULL)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Drive one cycle. The model is updated, and on a pop the expected
    // dataOut is queued. Outputs are stable when the task returns.
    task automatic drive(input logic en, input logic rw, input logic [DW-1:0] d);
        @(negedge Clk);
        EN = en; RW = rw; dataIn = d;
        if (en && Rst) begin
            if (!rw) begin
                if (model_stk.size() < DEPTH) model_stk.push_back(d);
            end else begin
                if (model_stk.size() > 0) model_out = model_stk.pop_back();
                sb.push_back(model_out);
            end
        end
        @(posedge Clk);
        #1;
        EN = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            EN = 1'b1; RW = 1'b0; dataIn = DW'($urandom);
            @(posedge Clk);
            #1;
            checks++;
            if (EMPTY !== 1'b1 || FULL !== 1'b0 || dataOut !== '0) begin
                failures++;
                $display("FAIL reset_hold: actual EMPTY=%b FULL=%b dataOut=%h required 1 0 0", EMPTY, FULL, dataOut);
            end
        end
        @(negedge Clk);
        EN = 1'b0;
        Rst = 1'b1;
        model_stk.delete();
        model_out = '0;
        // Nothing may have been pushed while reset was held.
        drive(1'b1, 1'b1, '0);
        exp_word = sb.pop_front();
        checks++;
        if (dataOut !== exp_word || EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL reset_pop: actual dataOut=%h EMPTY=%b required %h 1", dataOut, EMPTY, exp_word);
        end
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, DW'(2 * i));
        checks++;
        if (EMPTY !== 1'b0 || FULL !== 1'b0) begin
            failures++;
            $display("FAIL pp_flags: actual EMPTY=%b FULL=%b required 0 0", EMPTY, FULL);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, '0);
            exp_word = sb.pop_front();
            checks++;
            if (dataOut !== exp_word || dataOut !== DW'(6 - 2 * i)) begin
                failures++;
                $display("FAIL pp_pop%0d: actual=%h required=%h", i, dataOut, exp_word);
            end
            checks++;
            if (EMPTY !== (i == 3)) begin
                failures++;
                $display("FAIL pp_empty%0d: actual=%b required=%b", i, EMPTY, (i == 3));
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DW'(i));
        checks++;
        if (FULL !== 1'b1 || EMPTY !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full: actual FULL=%b EMPTY=%b required 1 0", FULL, EMPTY);
        end
        drive(1'b1, 1'b0, 4'h9);
        checks++;
        if (FULL !== 1'b1 || dataOut !== model_out) begin
            failures++;
            $display("FAIL ovf_drop: actual FULL=%b dataOut=%h required 1 %h", FULL, dataOut, model_out);
        end
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, '0);
            exp_word = sb.pop_front();
            checks++;
            if (dataOut !== exp_word || dataOut !== DW'((i < 8) ? 8 - i : 1)) begin
                failures++;
                $display("FAIL ovf_pop%0d: actual=%h required=%h", i, dataOut, exp_word);
            end
            checks++;
            if (FULL !== 1'b0 || EMPTY !== (i >= 7)) begin
                failures++;
                $display("FAIL ovf_flags%0d: actual FULL=%b EMPTY=%b required 0 %b", i, FULL, EMPTY, (i >= 7));
            end
        end
    endtask

    task automatic test_enable_gating();
        drive(1'b1, 1'b0, 4'h3);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b1, '0);
        exp_word = sb.pop_front();
        checks++;
        if (dataOut !== exp_word) begin
            failures++;
            $display("FAIL en_setup: actual=%h required=%h", dataOut, exp_word);
        end
        drive(1'b1, 1'b0, 4'h7);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom), DW'($urandom));
            checks++;
            if (dataOut !== model_out || EMPTY !== 1'b0 || FULL !== 1'b0) begin
                failures++;
                $display("FAIL en_hold%0d: actual dataOut=%h EMPTY=%b FULL=%b required %h 0 0", i, dataOut, EMPTY, FULL, model_out);
            end
        end
        // Drain. The stack must still hold exactly 7 then 3.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, '0);
            exp_word = sb.pop_front();
            checks++;
            if (dataOut !== exp_word) begin
                failures++;
                $display("FAIL en_drain%0d: actual=%h required=%h", i, dataOut, exp_word);
            end
        end
        checks++;
        if (EMPTY !== 1'b1 || dataOut !== 4'h3) begin
            failures++;
            $display("FAIL en_end: actual EMPTY=%b dataOut=%h required 1 3", EMPTY, dataOut);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] seq_d [6] = '{4'hA, 4'h0, 4'hB, 4'hC, 4'h0, 4'h0};
        logic          seq_r [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq_r[i], seq_d[i]);
            if (seq_r[i]) begin
                exp_word = sb.pop_front();
                checks++;
                if (dataOut !== exp_word) begin
                    failures++;
                    $display("FAIL b2b_pop%0d: actual=%h required=%h", i, dataOut, exp_word);
                end
            end
        end
        checks++;
        if (EMPTY !== 1'b1 || dataOut !== 4'hB) begin
            failures++;
            $display("FAIL b2b_end: actual EMPTY=%b dataOut=%h required 1 b", EMPTY, dataOut);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h2);
        drive(1'b1, 1'b0, 4'h3);
        drive(1'b1, 1'b1, '0);
        exp_word = sb.pop_front();
        checks++;
        if (dataOut !== exp_word) begin
            failures++;
            $display("FAIL ar_setup: actual=%h required=%h", dataOut, exp_word);
        end
        drive(1'b1, 1'b0, 4'h4);
        // Pulse reset between edges. The effect must be seen before the next edge.
        @(negedge Clk);
        #1 Rst = 1'b0;
        #1;
        checks++;
        if (EMPTY !== 1'b1 || FULL !== 1'b0 || dataOut !== '0) begin
            failures++;
            $display("FAIL ar_immediate: actual EMPTY=%b FULL=%b dataOut=%h required 1 0 0", EMPTY, FULL, dataOut);
        end
        #1 Rst = 1'b1;
        model_stk.delete();
        model_out = '0;
        drive(1'b1, 1'b1, '0);
        exp_word = sb.pop_front();
        checks++;
        if (dataOut !== exp_word || dataOut !== '0 || EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL ar_pop: actual dataOut=%h EMPTY=%b required %h 1", dataOut, EMPTY, exp_word);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_enable_gating();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lifo_buffer_register.md
# lifo_buffer_register

Synchronous last-in-first-out buffer register (hardware stack) holding `DEPTH` words of `DATA_WIDTH` bits. A single read/write select and an enable control each cycle's operation. EMPTY and FULL status flags are provided. The block is a leaf storage element for small datapaths that need reverse-order retrieval of a short burst of words.

## Interface
- `DATA_WIDTH`, default 4: word width in bits.
- `DEPTH`, default 8: number of storage entries; must be ≥ 2.
- `Clk`, input, 1: single clock; all state changes on the rising edge.
- `Rst`, input, 1: asynchronous, active-low reset.
- `EN`, input, 1: operation enable; when 0, the cycle is a no-op.
- `RW`, input, 1: operation select; 0 = write (push), 1 = read (pop).
- `dataIn`, input, `DATA_WIDTH`: word to push.
- `dataOut`, output, `DATA_WIDTH`: registered, last popped word.
- `EMPTY`, output, 1: high when the buffer holds 0 words.
- `FULL`, output, 1: high when the buffer holds `DEPTH` words.

## Operation
- **State:**
  - storage array `mem[0..DEPTH-1]`.
  - stack pointer `sp`, width `$clog2(DEPTH)+1`, range 0..`DEPTH`; `sp` equals the current word count.
- **Push** (`EN`=1, `RW`=0, `FULL`=0): `mem[sp] <= dataIn`; `sp <= sp+1`. `dataOut` is unchanged.
- **Pop** (`EN`=1, `RW`=1, `EMPTY`=0): `dataOut <= mem[sp-1]`; `sp <= sp-1`. The entry is not cleared.
- **Push when full:** ignored. `mem`, `sp` and `dataOut` are unchanged; the word is dropped with no error flag.
- **Pop when empty:** ignored. `dataOut` holds its previous value; `sp` stays 0.
- **`EN`=0:** no state change regardless of `RW` or `dataIn`.
- **Flags:** combinational decode of `sp`.
  - `EMPTY` = (`sp`==0).
  - `FULL` = (`sp`==`DEPTH`).
  - `EMPTY` and `FULL` are never high together.
- **Reset** (`Rst`=0, asynchronous, applies immediately and is held while low):
  - `sp` = 0, `dataOut` = 0, `EMPTY` = 1, `FULL` = 0.
  - `mem` contents are don't-care and are not reset.
  - Reset mid-operation discards all stored words.
- **Reset release:** synchronous use only; the first operation is taken on the first rising edge after `Rst` rises.

## Timing
- One operation per clock, sampled on the rising `Clk` edge.
- Push latency: the word is stored at the sampling edge; the flags reflect the new count immediately after that edge.
- Pop latency: `dataOut` shows the popped word immediately after the sampling edge, i.e. 1 cycle. It holds until the next successful pop or reset.
- Back-to-back push/pop in consecutive cycles is supported with no bubble.
  - A pop directly after a push returns that pushed word.
- No simultaneous push and pop: `RW` selects exactly one operation.
- There is no handshake; the user must respect `FULL`/`EMPTY` or accept dropped or ignored operations.

## Structure
- Shared package `lifo_pkg`: default `DATA_WIDTH`/`DEPTH` constants and a pointer-width helper, `$clog2(DEPTH)+1`.
- Optional sub-module `lifo_storage`: the register-file array with write port and read address, no reset.
- Pointer, flag and control logic stay in the top module.

## Test plan
- **Reset:** hold `Rst`=0 with `EN`=1 and random `dataIn` → `EMPTY`=1, `FULL`=0, `dataOut`=0, no pushes taken.
- **Push then pop:** push 0x0, 0x2, 0x4, 0x6 (`RW`=0, `EN`=1), then 4 pops (`RW`=1).
  - `dataOut` sequence is 0x6, 0x4, 0x2, 0x0.
  - `EMPTY` rises after the 4th pop.
- **Overflow:** push 0x1..0x8 (8 words) → `FULL`=1; push 0x9 → ignored; 8 pops → 0x8 down to 0x1; 9th pop → `dataOut` holds 0x1 and `EMPTY`=1.
- **Enable gating:** with 2 words stored, drive `EN`=0 and toggle `RW`/`dataIn` for 5 cycles → `sp`, flags and `dataOut` unchanged.
- **Interleave:** push 0xA, pop → 0xA; push 0xB, push 0xC, pop → 0xC, pop → 0xB; `EMPTY`=1 at the end.
- **Async reset mid-run:** with 3 words stored, pulse `Rst` low between clock edges → `EMPTY`=1 immediately, `dataOut`=0; a following pop leaves `dataOut` at 0.
